fifo_rd_ctrl: RTL

Read-domain controller for the async FIFO. It is the reader counterpart to the write-side memory and pointer logic.
- Synchronises the write-domain Gray pointer into r_clk and maintains the binary and Gray read pointers.
- Generates the empty flag and drives the read address into the FIFO memory.
- Presents memory data through a registered valid/ready output stage (one-word prefetch).

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_sync2.sv | 33 +++
 rtl/fifo_rd_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: Gray conversion and configuration check.
// Used by both the read-side and write-side pointer logic.
package fifo_pkg;

    localparam int unsigned FN_W = 32;

    // Binary to Gray conversion. Narrower pointers are zero-extended by the caller.
    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary conversion. Zero-extended upper bits decode to zero.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] gray);
        logic [FN_W-1:0] bin;
        bin[FN_W-1] = gray[FN_W-1];
        for (int i = FN_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    // Depth must be exactly half the pointer range so the wrap bit separates full from empty.
    function automatic bit depth_ok(input int unsigned f_depth, input int unsigned p_size);
        return (p_size >= 2) && (f_depth == (32'd1 << (p_size - 1)));
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Generic two-flop synchroniser for a Gray-coded pointer bus.
module fifo_sync2 #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sync1_d, sync1_q;
    logic [W-1:0] sync2_d, sync2_q;

    // Shift the asynchronous bus through two stages.
    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    // Synchroniser flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller for the async FIFO: write-pointer sync, read pointers,
// empty flag, and a one-word registered valid/ready output stage.
// Optional: define FIFO_RD_LEVEL_EN to add the r_level fill-level output.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned D_SIZE  = 8,
    parameter int unsigned F_DEPTH = 16,
    parameter int unsigned P_SIZE  = 5
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic [P_SIZE-1:0] w_gray_ptr,
    input  logic [D_SIZE-1:0] mem_rdata,
    input  logic              r_ready,
    output logic [P_SIZE-2:0] r_addr,
    output logic [P_SIZE-1:0] r_gray_ptr,
    output logic              r_empty,
    output logic              r_valid,
    output logic [D_SIZE-1:0] r_data
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [P_SIZE-1:0] r_level
`endif
);

    if (!depth_ok(F_DEPTH, P_SIZE)) begin : g_cfg_err
        $error("fifo_rd_ctrl: F_DEPTH must equal 2**(P_SIZE-1)");
    end

    logic [P_SIZE-1:0] wq2_gray;
    logic              fetch_c;

    logic [P_SIZE-1:0] r_bin_d,   r_bin_q;
    logic [P_SIZE-1:0] r_gray_d,  r_gray_q;
    logic              r_empty_d, r_empty_q;
    logic              r_valid_d, r_valid_q;
    logic [D_SIZE-1:0] r_data_d,  r_data_q;
`ifdef FIFO_RD_LEVEL_EN
    logic [P_SIZE-1:0] r_level_d, r_level_q;
`endif

    fifo_sync2 #(.W(P_SIZE)) u_wptr_sync (
        .clk (r_clk),
        .rst (r_rst),
        .d   (w_gray_ptr),
        .q   (wq2_gray)
    );

    // Next-state: fetch into the output register when a word is available and the slot frees up.
    always_comb begin
        fetch_c   = !r_empty_q && (!r_valid_q || r_ready);
        r_bin_d   = r_bin_q + P_SIZE'(fetch_c);
        r_gray_d  = P_SIZE'(bin2gray(FN_W'(r_bin_d)));
        r_empty_d = (r_gray_d == wq2_gray);
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        if (fetch_c) begin
            r_valid_d = 1'b1;
            r_data_d  = mem_rdata;
        end else if (r_ready) begin
            r_valid_d = 1'b0;
        end
`ifdef FIFO_RD_LEVEL_EN
        r_level_d = P_SIZE'(gray2bin(FN_W'(wq2_gray))) - r_bin_d;
`endif
    end

    // State registers; reset drops any held word and all pointer state.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_bin_q   <= '0;
            r_gray_q  <= '0;
            r_empty_q <= 1'b1;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
`ifdef FIFO_RD_LEVEL_EN
            r_level_q <= '0;
`endif
        end else begin
            r_bin_q   <= r_bin_d;
            r_gray_q  <= r_gray_d;
            r_empty_q <= r_empty_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
`ifdef FIFO_RD_LEVEL_EN
            r_level_q <= r_level_d;
`endif
        end
    end

    assign r_addr     = r_bin_q[P_SIZE-2:0];
    assign r_gray_ptr = r_gray_q;
    assign r_empty    = r_empty_q;
    assign r_valid    = r_valid_q;
    assign r_data     = r_data_q;
`ifdef FIFO_RD_LEVEL_EN
    assign r_level    = r_level_q;
`endif

endmodule
